// File: rtl/demux_1x4_scheduler.sv
// 1-to-4 demultiplexing scheduler: one valid/ready input stream fanned out to four
// one-entry channel registers, targeted by round-robin pointer or explicit destination.
module demux_1x4_scheduler #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             mode,
  input  logic [1:0]       dest_sel,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic [WIDTH-1:0] dout4,
  output logic [3:0]       dout_valid,
  input  logic [3:0]       dout_ready
);

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned PTR_W  = 2;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  data_q [NUM_CH];
  logic [WIDTH-1:0]  data_d [NUM_CH];
  logic [NUM_CH-1:0] valid_q, valid_d;

  logic [PTR_W-1:0]  tgt;
  logic              accept;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] drain;

  // Target selection and input handshake; a draining channel can take a new word.
  always_comb begin
    tgt       = mode ? dest_sel : rr_ptr_q;
    din_ready = rst_n & (~valid_q[tgt] | dout_ready[tgt]);
    accept    = din_valid & din_ready;
  end

  // Per-channel load/drain strobes.
  always_comb begin
    load  = '0;
    drain = valid_q & dout_ready;
    for (int k = 0; k < NUM_CH; k++) begin
      load[k] = accept & (tgt == PTR_W'(k));
    end
  end

  // Next-state: load wins over drain so a simultaneous drain+load keeps valid high.
  always_comb begin
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < NUM_CH; k++) begin
      data_d[k] = data_q[k];
      if (load[k]) begin
        data_d[k]  = din;
        valid_d[k] = 1'b1;
      end else if (drain[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    if (accept && !mode) begin
      rr_ptr_d = rr_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      valid_q  <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      for (int k = 0; k < NUM_CH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  always_comb begin
    sel        = tgt;
    dout1      = data_q[0];
    dout2      = data_q[1];
    dout3      = data_q[2];
    dout4      = data_q[3];
    dout_valid = valid_q;
  end

endmodule

// File: tb/tb_demux_1x4_scheduler.sv
// Directed self-checking bench for demux_1x4_scheduler.
module tb_demux_1x4_scheduler;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             mode;
  logic [1:0]       dest_sel;
  logic [1:0]       sel;
  logic [WIDTH-1:0] dout1, dout2, dout3, dout4;
  logic [3:0]       dout_valid;
  logic [3:0]       dout_ready;

  int checks = 0;
  int errors = 0;

  demux_1x4_scheduler #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .mode(mode), .dest_sel(dest_sel), .sel(sel),
    .dout1(dout1), .dout2(dout2), .dout3(dout3), .dout4(dout4),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; din_valid = 1'b0; din = '0; mode = 1'b0; dest_sel = 2'd0; dout_ready = 4'b0000;
    tick();
    rst_n = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din_valid = 1'b1; din = 4'hF; mode = 1'b0; dest_sel = 2'd0; dout_ready = 4'b0000;
    tick();
    tick();
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL rst_din_ready got %b exp 0", din_ready); end
    checks++; if (dout_valid !== 4'b0000) begin errors++; $display("FAIL rst_dout_valid got %b exp 0000", dout_valid); end
    checks++; if ({dout1, dout2, dout3, dout4} !== 16'h0000) begin errors++;
      $display("FAIL rst_data got %h exp 0000", {dout1, dout2, dout3, dout4}); end
    rst_n = 1'b1;
    settle();
    checks++; if (din_ready !== 1'b1 || sel !== 2'd0) begin errors++;
      $display("FAIL rst_release_ready got ready=%b sel=%0d exp ready=1 sel=0", din_ready, sel); end
    tick();
    din_valid = 1'b0;
    settle();
    checks++; if (dout_valid !== 4'b0001 || dout1 !== 4'hF) begin errors++;
      $display("FAIL rst_first_accept got valid=%b dout1=%h exp 0001 F", dout_valid, dout1); end
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] vec [4];
    logic [3:0] exp_v;
    vec[0] = 4'h1; vec[1] = 4'h3; vec[2] = 4'h7; vec[3] = 4'hF;
    do_reset();
    dout_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      din = vec[i]; din_valid = 1'b1;
      settle();
      checks++; if (sel !== 2'(i) || din_ready !== 1'b1) begin errors++;
        $display("FAIL rr_sel_%0d got sel=%0d ready=%b exp sel=%0d ready=1", i, sel, din_ready, i); end
      tick();
      exp_v = 4'b0001 << i;
      checks++; if (dout_valid !== exp_v) begin errors++;
        $display("FAIL rr_pulse_%0d got %b exp %b", i, dout_valid, exp_v); end
    end
    din_valid = 1'b0;
    settle();
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rr_wrap got sel=%0d exp 0", sel); end
    tick();
    checks++; if (dout_valid !== 4'b0000) begin errors++; $display("FAIL rr_drained got %b exp 0000", dout_valid); end
    checks++; if ({dout1, dout2, dout3, dout4} !== 16'h137F) begin errors++;
      $display("FAIL rr_data got %h exp 137f", {dout1, dout2, dout3, dout4}); end
  endtask

  task automatic test_backpressure();
    do_reset();
    dout_ready = 4'b0000; mode = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      din = 4'(i); din_valid = 1'b1;
      tick();
    end
    checks++; if (dout_valid !== 4'b1111) begin errors++; $display("FAIL bp_full got %b exp 1111", dout_valid); end
    din = 4'h5;
    settle();
    checks++; if (din_ready !== 1'b0 || sel !== 2'd0) begin errors++;
      $display("FAIL bp_stall got ready=%b sel=%0d exp ready=0 sel=0", din_ready, sel); end
    tick();
    checks++; if (dout1 !== 4'h1) begin errors++; $display("FAIL bp_hold got dout1=%h exp 1", dout1); end
    dout_ready = 4'b0001;
    settle();
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL bp_release got ready=%b exp 1", din_ready); end
    tick();
    din_valid = 1'b0; dout_ready = 4'b0000;
    settle();
    checks++; if (dout1 !== 4'h5 || dout_valid !== 4'b1111) begin errors++;
      $display("FAIL bp_load got dout1=%h valid=%b exp 5 1111", dout1, dout_valid); end
    checks++; if ({dout2, dout3, dout4} !== 12'h234) begin errors++;
      $display("FAIL bp_others got %h exp 234", {dout2, dout3, dout4}); end
  endtask

  task automatic test_directed();
    do_reset();
    // One round-robin accept first so the pointer sits at 1.
    dout_ready = 4'b1111; mode = 1'b0; din = 4'h8; din_valid = 1'b1;
    tick();
    dout_ready = 4'b1011; mode = 1'b1; dest_sel = 2'd2; din = 4'hA;
    settle();
    checks++; if (sel !== 2'd2 || din_ready !== 1'b1) begin errors++;
      $display("FAIL dir_sel got sel=%0d ready=%b exp 2 1", sel, din_ready); end
    tick();
    checks++; if (dout3 !== 4'hA || dout_valid !== 4'b0100) begin errors++;
      $display("FAIL dir_load_a got dout3=%h valid=%b exp a 0100", dout3, dout_valid); end
    din = 4'hB;
    settle();
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL dir_stall_b got ready=%b exp 0", din_ready); end
    tick();
    checks++; if (dout3 !== 4'hA) begin errors++; $display("FAIL dir_hold_a got dout3=%h exp a", dout3); end
    dout_ready = 4'b1111;
    settle();
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL dir_release got ready=%b exp 1", din_ready); end
    tick();
    din_valid = 1'b0; dout_ready = 4'b0000;
    settle();
    checks++; if (dout3 !== 4'hB || dout_valid !== 4'b0100) begin errors++;
      $display("FAIL dir_load_b got dout3=%h valid=%b exp b 0100", dout3, dout_valid); end
    mode = 1'b0;
    settle();
    checks++; if (sel !== 2'd1) begin errors++; $display("FAIL dir_rr_kept got sel=%0d exp 1", sel); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mode = 1'b1; dest_sel = 2'd1; dout_ready = 4'b0000; din = 4'h6; din_valid = 1'b1;
    tick();
    checks++; if (dout2 !== 4'h6 || dout_valid !== 4'b0010) begin errors++;
      $display("FAIL b2b_first got dout2=%h valid=%b exp 6 0010", dout2, dout_valid); end
    dout_ready = 4'b0010; din = 4'h9;
    settle();
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", din_ready); end
    tick();
    din_valid = 1'b0; dout_ready = 4'b0000;
    settle();
    checks++; if (dout2 !== 4'h9 || dout_valid !== 4'b0010) begin errors++;
      $display("FAIL b2b_swap got dout2=%h valid=%b exp 9 0010", dout2, dout_valid); end
    // Ready on an empty channel must not disturb anything.
    dout_ready = 4'b1101;
    tick();
    checks++; if (dout_valid !== 4'b0010 || dout2 !== 4'h9) begin errors++;
      $display("FAIL b2b_idle_ready got valid=%b dout2=%h exp 0010 9", dout_valid, dout2); end
    dout_ready = 4'b0000;
  endtask

  task automatic test_reset_mid();
    logic [1:0] dests [3];
    dests[0] = 2'd0; dests[1] = 2'd1; dests[2] = 2'd3;
    do_reset();
    mode = 1'b1; dout_ready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      dest_sel = dests[i]; din = 4'(i + 4'hC); din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    settle();
    checks++; if (dout_valid !== 4'b1011) begin errors++; $display("FAIL mid_loaded got %b exp 1011", dout_valid); end
    rst_n = 1'b0;
    tick();
    checks++; if (dout_valid !== 4'b0000 || {dout1, dout2, dout3, dout4} !== 16'h0000) begin errors++;
      $display("FAIL mid_cleared got valid=%b data=%h exp 0000 0000", dout_valid, {dout1, dout2, dout3, dout4}); end
    rst_n = 1'b1; mode = 1'b0; din = 4'hC; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    settle();
    checks++; if (dout_valid !== 4'b0001 || dout1 !== 4'hC) begin errors++;
      $display("FAIL mid_first got valid=%b dout1=%h exp 0001 c", dout_valid, dout1); end
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; mode = 1'b0; dest_sel = 2'd0; dout_ready = 4'b0000;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
